// File: rtl/alu_share_arbiter_pkg.sv
// Shared constants, op codes and FSM state type for the two-requester ALU arbiter.
package alu_share_arbiter_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned OP_W   = 3;

   localparam logic [OP_W-1:0] OP_ADD = 3'b010;
   localparam logic [OP_W-1:0] OP_SUB = 3'b110;
   localparam logic [OP_W-1:0] OP_AND = 3'b000;
   localparam logic [OP_W-1:0] OP_OR  = 3'b001;
   localparam logic [OP_W-1:0] OP_SLT = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   function automatic logic is_legal_op(input logic [OP_W-1:0] op);
      logic legal;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: legal = 1'b1;
         default:                               legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Existing 32-bit ALU: ADD, SUB, AND, OR and unsigned SLT; unknown codes yield zero.
module ArithmeticLogicUnit
   import alu_share_arbiter_pkg::*;
(
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic [OP_W-1:0]   alu_control_i,
   output logic [DATA_W-1:0] result_o,
   output logic              zero_o
);

   always_comb begin
      result_o = '0;
      case (alu_control_i)
         OP_ADD:  result_o = a_i + b_i;
         OP_SUB:  result_o = a_i - b_i;
         OP_AND:  result_o = a_i & b_i;
         OP_OR:   result_o = a_i | b_i;
         OP_SLT:  result_o = DATA_W'(a_i < b_i);
         default: result_o = '0;
      endcase
   end

   assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; one transaction in flight
// through IDLE -> EXEC -> RESP.
module alu_share_arbiter
   import alu_share_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              reset,

   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [OP_W-1:0]   req0_op,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic [DATA_W-1:0] rsp0_result,
   output logic              rsp0_zero,
   output logic              rsp0_err,

   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [OP_W-1:0]   req1_op,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp1_result,
   output logic              rsp1_zero,
   output logic              rsp1_err,

   output logic              busy
);

   state_t            state_q;
   logic              owner_q;
   logic              last_grant_q;
   logic [OP_W-1:0]   op_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [DATA_W-1:0] result_q;
   logic              zero_q;
   logic              err_q;

   logic              grant_valid;
   logic              grant_id;
   logic [OP_W-1:0]   sel_op;
   logic [DATA_W-1:0] sel_a;
   logic [DATA_W-1:0] sel_b;
   logic              owner_rsp_ready;
   logic [DATA_W-1:0] alu_result;
   logic              alu_zero;
   logic              op_legal;

   // Grant selection: a lone requester wins; on a tie the one not served last wins.
   always_comb begin
      grant_valid = 1'b0;
      grant_id    = 1'b0;
      if (req0_valid && req1_valid) begin
         grant_valid = 1'b1;
         grant_id    = ~last_grant_q;
      end else if (req0_valid) begin
         grant_valid = 1'b1;
         grant_id    = 1'b0;
      end else if (req1_valid) begin
         grant_valid = 1'b1;
         grant_id    = 1'b1;
      end
   end

   assign sel_op          = grant_id ? req1_op : req0_op;
   assign sel_a           = grant_id ? req1_a  : req0_a;
   assign sel_b           = grant_id ? req1_b  : req0_b;
   assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;
   assign op_legal        = is_legal_op(op_q);

   ArithmeticLogicUnit u_alu (
      .a_i           (a_q),
      .b_i           (b_q),
      .alu_control_i (op_q),
      .result_o      (alu_result),
      .zero_o        (alu_zero)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         op_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         result_q     <= '0;
         zero_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (grant_valid) begin
                  op_q         <= sel_op;
                  a_q          <= sel_a;
                  b_q          <= sel_b;
                  owner_q      <= grant_id;
                  last_grant_q <= grant_id;
                  state_q      <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               // Illegal codes report err with a forced zero result and zero flag low.
               if (op_legal) begin
                  result_q <= alu_result;
                  zero_q   <= alu_zero;
                  err_q    <= 1'b0;
               end else begin
                  result_q <= '0;
                  zero_q   <= 1'b0;
                  err_q    <= 1'b1;
               end
               state_q <= ST_RESP;
            end
            ST_RESP: begin
               if (owner_rsp_ready) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req0_ready  = (state_q == ST_IDLE) && grant_valid && !grant_id;
   assign req1_ready  = (state_q == ST_IDLE) && grant_valid &&  grant_id;
   assign rsp0_valid  = (state_q == ST_RESP) && !owner_q;
   assign rsp1_valid  = (state_q == ST_RESP) &&  owner_q;
   assign rsp0_result = result_q;
   assign rsp1_result = result_q;
   assign rsp0_zero   = zero_q;
   assign rsp1_zero   = zero_q;
   assign rsp0_err    = err_q;
   assign rsp1_err    = err_q;
   assign busy        = (state_q != ST_IDLE);

endmodule
